// File: rtl/nand_sched_pkg.sv
// Shared types and defaults for the NAND bus scheduler and its round-robin picker.
package nand_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    TURN
  } sched_state_t;

  localparam int DEF_NUM_WAYS = 8;
  localparam int DEF_TURN_CYC = 2;
  localparam int DEF_MAX_HOLD = 4096;

  // Index width for a way count; a single way still needs one bit.
  function automatic int way_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/nand_rr_pick.sv
// Combinational round-robin picker: rotates elig so ptr is at bit 0, finds the
// lowest set bit, then rotates the offset back into an absolute way index.
module nand_rr_pick
  import nand_sched_pkg::*;
#(
  parameter int N = DEF_NUM_WAYS,
  localparam int W = way_w(N)
) (
  input  logic [N-1:0] elig,
  input  logic [W-1:0] ptr,
  output logic         valid,
  output logic [W-1:0] idx
);

  logic [N-1:0] rot;
  logic [W-1:0] off;
  logic [W-1:0] src;

  always_comb begin
    rot   = '0;
    off   = '0;
    src   = '0;
    for (int i = 0; i < N; i++) begin
      src    = W'(i) + ptr;
      rot[i] = elig[src];
    end
    // Scan downwards so the lowest rotated position (closest to ptr) wins.
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) off = W'(i);
    end
    valid = |elig;
    idx   = ptr + off;
  end

endmodule

// File: rtl/nand_bus_scheduler.sv
// Round-robin owner of one shared NAND bus: grants one way at a time behind its
// chip enable, forces a turnaround gap between owners and a release on overrun.
module nand_bus_scheduler
  import nand_sched_pkg::*;
#(
  parameter int NUM_WAYS = DEF_NUM_WAYS,
  parameter int TURN_CYC = DEF_TURN_CYC,
  parameter int MAX_HOLD = DEF_MAX_HOLD,
  localparam int WAY_W  = way_w(NUM_WAYS),
  localparam int HOLD_W = $clog2(MAX_HOLD),
  localparam int TURN_W = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_WAYS-1:0] req,
  input  logic [NUM_WAYS-1:0] release_pulse,
  input  logic [NUM_WAYS-1:0] rb_n,
  output logic [NUM_WAYS-1:0] gnt,
  output logic                gnt_valid,
  output logic [WAY_W-1:0]    gnt_id,
  output logic [NUM_WAYS-1:0] cen,
  output logic [NUM_WAYS-1:0] busy,
  output logic                timeout_err
);

  logic [NUM_WAYS-1:0] rb_meta;
  logic [NUM_WAYS-1:0] rb_sync;
  logic [NUM_WAYS-1:0] elig;

  sched_state_t        state_q, state_d;
  logic [WAY_W-1:0]    ptr_q, ptr_d;
  logic [WAY_W-1:0]    gnt_id_d;
  logic [NUM_WAYS-1:0] gnt_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [TURN_W-1:0]   turn_q, turn_d;
  logic                tmo_d;
  logic                pick_valid;
  logic [WAY_W-1:0]    pick_idx;
  logic                owner_rel;
  logic                hold_end;

  // R/B pins are asynchronous; the flops reset to "ready" so busy starts clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rb_meta <= '1;
      rb_sync <= '1;
    end else begin
      rb_meta <= rb_n;
      rb_sync <= rb_meta;
    end
  end

  assign busy = ~rb_sync;
  assign elig = req & rb_sync;

  nand_rr_pick #(.N(NUM_WAYS)) u_pick (
    .elig  (elig),
    .ptr   (ptr_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  assign owner_rel = release_pulse[gnt_id];
  assign hold_end  = (hold_q == HOLD_W'(MAX_HOLD - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      hold_q      <= '0;
      turn_q      <= '0;
      gnt         <= '0;
      gnt_valid   <= 1'b0;
      gnt_id      <= '0;
      cen         <= '1;
      timeout_err <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      hold_q      <= hold_d;
      turn_q      <= turn_d;
      gnt         <= gnt_d;
      gnt_valid   <= |gnt_d;
      gnt_id      <= gnt_id_d;
      cen         <= ~gnt_d;
      timeout_err <= tmo_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    gnt_d    = gnt;
    gnt_id_d = gnt_id;
    hold_d   = hold_q;
    turn_d   = turn_q;
    tmo_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          gnt_d    = NUM_WAYS'(1) << pick_idx;
          gnt_id_d = pick_idx;
          ptr_d    = pick_idx + WAY_W'(1);
          hold_d   = '0;
          state_d  = GRANT;
        end
      end
      GRANT: begin
        // A release landing on the final hold cycle wins over the timeout.
        if (owner_rel || hold_end) begin
          gnt_d   = '0;
          hold_d  = '0;
          turn_d  = '0;
          tmo_d   = !owner_rel;
          state_d = (TURN_CYC == 0) ? IDLE : TURN;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      TURN: begin
        if (turn_q == TURN_W'(TURN_CYC - 1)) begin
          turn_d  = '0;
          state_d = IDLE;
        end else begin
          turn_d = turn_q + TURN_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_nand_bus_scheduler.sv
// Scoreboard bench: expected grants are queued as stimulus is applied and
// compared as the scheduler hands out the bus.
module tb_nand_bus_scheduler;

  typedef struct {
    int id;
    int gap;
    int len;
  } grant_exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] req = '0, rel_man = '0, rel_auto = '0, rb_n = '1;
  logic [7:0] release_pulse;
  logic [7:0] gnt, cen, busy;
  logic       gnt_valid, timeout_err;
  logic [2:0] gnt_id;

  logic [7:0] req_b = '0, rel_b = '0, rb_b = '1;
  logic [7:0] gnt_b, cen_b, busy_b;
  logic       gnt_valid_b, timeout_err_b;
  logic [2:0] gnt_id_b;

  int checkCount = 0;
  int errCount = 0;
  int autoHold = 0;
  int tmoCount = 0;

  grant_exp_t expQ[$];
  grant_exp_t curExp;
  logic       haveCur = 1'b0;
  logic       prevValid = 1'b0;
  logic [2:0] prevId = '0;
  int         curLen = 0;
  int         idleRun = 0;

  assign release_pulse = rel_man | rel_auto;

  always #5 clk = ~clk;

  nand_bus_scheduler #(.NUM_WAYS(8), .TURN_CYC(2), .MAX_HOLD(16)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .release_pulse(release_pulse), .rb_n(rb_n),
    .gnt(gnt), .gnt_valid(gnt_valid), .gnt_id(gnt_id), .cen(cen), .busy(busy),
    .timeout_err(timeout_err)
  );

  nand_bus_scheduler #(.NUM_WAYS(8), .TURN_CYC(0), .MAX_HOLD(16)) dut_noturn (
    .clk(clk), .rst_n(rst_n), .req(req_b), .release_pulse(rel_b), .rb_n(rb_b),
    .gnt(gnt_b), .gnt_valid(gnt_valid_b), .gnt_id(gnt_id_b), .cen(cen_b), .busy(busy_b),
    .timeout_err(timeout_err_b)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] r, input logic [7:0] rel, input logic [7:0] rb);
    req     = r;
    rel_man = rel;
    rb_n    = rb;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pushGrant(input int id, input int gap, input int len);
    grant_exp_t e;
    e.id  = id;
    e.gap = gap;
    e.len = len;
    expQ.push_back(e);
  endtask

  // Grant monitor, invariants and the auto-releasing owner model.
  always @(posedge clk) begin
    #2;
    if (!rst_n) begin
      haveCur   = 1'b0;
      prevValid = 1'b0;
      prevId    = '0;
      curLen    = 0;
      idleRun   = 0;
      rel_auto  = '0;
    end else begin
      checkOutput("cen_vs_gnt", cen, 32'(8'(~gnt)));
      checkOutput("gnt_onehot", 32'($countones(gnt) <= 1), 1);
      checkOutput("gnt_valid_or", gnt_valid, |gnt);
      checkOutput("b_cen_vs_gnt", cen_b, 32'(8'(~gnt_b)));
      if (timeout_err) tmoCount++;
      if (prevValid && (!gnt_valid || gnt_id != prevId) && haveCur && curExp.len >= 0)
        checkOutput("grant_len", curLen, curExp.len);
      if (gnt_valid && (!prevValid || gnt_id != prevId)) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected_grant", gnt_id, 32'hFFFF_FFFF);
          haveCur = 1'b0;
        end else begin
          curExp  = expQ.pop_front();
          haveCur = 1'b1;
          checkOutput("grant_id", gnt_id, curExp.id);
          checkOutput("grant_cen", cen, 32'(8'(~(8'h01 << curExp.id))));
          if (curExp.gap >= 0) checkOutput("grant_gap", idleRun, curExp.gap);
        end
        curLen = 1;
      end else if (gnt_valid) begin
        curLen++;
      end
      idleRun   = gnt_valid ? 0 : idleRun + 1;
      prevValid = gnt_valid;
      prevId    = gnt_id;
      rel_auto  = '0;
      if (autoHold > 0 && gnt_valid && curLen == autoHold + 1) rel_auto[gnt_id] = 1'b1;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int budget;
    applyStimulus(8'h00, 8'h00, 8'hFF);
    tick(3);
    checkOutput("rst_gnt", gnt, 8'h00);
    checkOutput("rst_valid", gnt_valid, 0);
    checkOutput("rst_id", gnt_id, 0);
    checkOutput("rst_cen", cen, 8'hFF);
    checkOutput("rst_busy", busy, 8'h00);
    checkOutput("rst_tmo", timeout_err, 0);
    checkOutput("rst_b_cen", cen_b, 8'hFF);
    rst_n = 1'b1;
    tick(2);

    // Ways 0 and 2 requesting: 0 first, then 2 after the turnaround.
    pushGrant(0, -1, -1);
    applyStimulus(8'h05, 8'h00, 8'hFF);
    tick(1);
    checkOutput("t2_gnt0", gnt, 8'h01);
    checkOutput("t2_cen0", cen, 8'hFE);
    applyStimulus(8'h04, 8'h00, 8'hFF);
    tick(1);
    pushGrant(2, 3, -1);
    applyStimulus(8'h04, 8'h01, 8'hFF);
    tick(1);
    applyStimulus(8'h04, 8'h00, 8'hFF);
    checkOutput("t2_turn1_gnt", gnt, 8'h00);
    checkOutput("t2_turn1_cen", cen, 8'hFF);
    tick(1);
    checkOutput("t2_turn2_cen", cen, 8'hFF);
    tick(1);
    checkOutput("t2_idle_cen", cen, 8'hFF);
    tick(1);
    checkOutput("t2_gnt2", gnt, 8'h04);
    checkOutput("t2_cen2", cen, 8'hFB);
    applyStimulus(8'h00, 8'h04, 8'hFF);
    tick(1);
    applyStimulus(8'h00, 8'h00, 8'hFF);
    tick(4);

    // Reset while way 3 owns the bus.
    pushGrant(3, -1, -1);
    applyStimulus(8'h08, 8'h00, 8'hFF);
    tick(1);
    checkOutput("t3_pre_gnt", gnt, 8'h08);
    tick(2);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("t3_async_gnt", gnt, 8'h00);
    checkOutput("t3_async_cen", cen, 8'hFF);
    checkOutput("t3_async_valid", gnt_valid, 0);
    checkOutput("t3_async_id", gnt_id, 0);

    // All ways requesting after reset: pointer restarts at way 0.
    applyStimulus(8'hFF, 8'h00, 8'hFF);
    autoHold = 3;
    for (int w = 0; w < 9; w++) pushGrant(w % 8, (w == 0) ? -1 : 3, 4);
    tick(2);
    rst_n = 1'b1;
    budget = 0;
    while (expQ.size() > 0 && budget < 200) begin
      tick(1);
      budget++;
    end
    checkOutput("t4_drain", expQ.size(), 0);
    applyStimulus(8'h00, 8'h00, 8'hFF);
    budget = 0;
    while (gnt_valid && budget < 50) begin
      tick(1);
      budget++;
    end
    checkOutput("t4_released", gnt_valid, 0);
    autoHold = 0;
    tick(4);

    // Way 4 busy: not eligible until R/B has crossed the synchroniser.
    applyStimulus(8'h00, 8'h00, 8'hEF);
    tick(3);
    checkOutput("t5_busy_set", busy, 8'h10);
    applyStimulus(8'h10, 8'h00, 8'hEF);
    tick(6);
    checkOutput("t5_no_grant", gnt, 8'h00);
    pushGrant(4, -1, -1);
    applyStimulus(8'h10, 8'h00, 8'hFF);
    tick(1);
    checkOutput("t5_busy_hold", busy, 8'h10);
    tick(1);
    checkOutput("t5_busy_clear", busy, 8'h00);
    checkOutput("t5_gnt_late", gnt, 8'h00);
    tick(1);
    checkOutput("t5_gnt4", gnt, 8'h10);
    applyStimulus(8'h00, 8'h10, 8'hFF);
    tick(1);
    applyStimulus(8'h00, 8'h00, 8'hFF);
    tick(4);

    // Way 1 never releases; a foreign release[5] is ignored.
    pushGrant(1, -1, 16);
    applyStimulus(8'h02, 8'h00, 8'hFF);
    tick(1);
    checkOutput("t6_gnt1", gnt, 8'h02);
    applyStimulus(8'h00, 8'h00, 8'hFF);
    for (int k = 2; k <= 16; k++) begin
      tick(1);
      checkOutput("t6_hold", gnt, 8'h02);
      applyStimulus(8'h00, (k == 5) ? 8'h20 : 8'h00, 8'hFF);
    end
    tick(1);
    checkOutput("t6_drop", gnt, 8'h00);
    checkOutput("t6_tmo", timeout_err, 1);
    checkOutput("t6_id_hold", gnt_id, 1);
    tick(1);
    checkOutput("t6_tmo_pulse", timeout_err, 0);
    tick(3);

    // Release on the last allowed hold cycle: normal release, no error.
    pushGrant(2, -1, 16);
    applyStimulus(8'h04, 8'h00, 8'hFF);
    tick(1);
    checkOutput("t7_gnt2", gnt, 8'h04);
    applyStimulus(8'h00, 8'h00, 8'hFF);
    for (int k = 2; k <= 16; k++) begin
      tick(1);
      applyStimulus(8'h00, (k == 16) ? 8'h04 : 8'h00, 8'hFF);
    end
    tick(1);
    applyStimulus(8'h00, 8'h00, 8'hFF);
    checkOutput("t7_drop", gnt, 8'h00);
    checkOutput("t7_no_tmo", timeout_err, 0);
    tick(1);
    checkOutput("t7_no_tmo_late", timeout_err, 0);
    tick(3);

    // Zero turnaround: one IDLE cycle between owners 6 and 7.
    req_b = 8'hC0;
    tick(1);
    checkOutput("t8_gnt6", gnt_b, 8'h40);
    checkOutput("t8_cen6", cen_b, 8'hBF);
    rel_b = 8'h40;
    tick(1);
    rel_b = 8'h00;
    checkOutput("t8_idle_gnt", gnt_b, 8'h00);
    checkOutput("t8_idle_cen", cen_b, 8'hFF);
    tick(1);
    checkOutput("t8_gnt7", gnt_b, 8'h80);
    checkOutput("t8_cen7", cen_b, 8'h7F);
    checkOutput("t8_id7", gnt_id_b, 7);
    req_b = 8'h00;
    rel_b = 8'h80;
    tick(1);
    rel_b = 8'h00;
    checkOutput("t8_drop", gnt_valid_b, 0);
    checkOutput("t8_id_hold", gnt_id_b, 7);
    checkOutput("t8_b_tmo", timeout_err_b, 0);
    tick(3);

    checkOutput("sb_empty", expQ.size(), 0);
    checkOutput("tmo_count", tmoCount, 1);
    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule

// File: doc/nand_bus_scheduler.md
Name: nand_bus_scheduler

Overview:
- Shares one NAND bus (DQ/DQS/CLE/ALE/WRN) between NUM_WAYS chip targets behind per-way chip enables.
- Arbitrates between per-way command engines using round-robin order. A way is eligible only while its chip reports ready (R/B high).
- Drives the active-low chip enables and inserts a bus turnaround gap between owners.
- Sits between the per-way command engines and the bus PHY, one instance per bus.

Parameters:
- NUM_WAYS, 8, number of chip targets (CE lines) on the bus; power of two, 2..16.
- TURN_CYC, 2, idle cycles with all CE high between two grants; 0..15.
- MAX_HOLD, 4096, maximum grant length in cycles before a forced release.

Ports:
- CLK  in  1  system clock.
- RST_N  in  1  reset. Asynchronous assert, active low.
- req  in  NUM_WAYS  per-way bus request (level).
- release  in  NUM_WAYS  per-way end-of-ownership pulse. Only the bit of the current owner is honoured.
- rb_n  in  NUM_WAYS  raw ready/busy pins from the chips (asynchronous); 1 = ready.
- gnt  out  NUM_WAYS  one-hot grant; all-zero when no owner.
- gnt_valid  out  1  OR of gnt.
- gnt_id  out  clog2(NUM_WAYS)  index of the owner; holds the last owner when gnt_valid=0.
- cen  out  NUM_WAYS  active-low chip enables; cen[w]=0 only while gnt[w]=1.
- busy  out  NUM_WAYS  synchronised busy status (~rb_sync).
- timeout_err  out  1  one-cycle pulse on a forced release.

Behaviour:
- Reset values (asynchronous, taking effect mid-operation as well):
  - gnt=0, gnt_valid=0, gnt_id=0, cen=all ones, timeout_err=0.
  - busy=0: the sync flops reset to 1 (ready).
  - Round-robin pointer=0, state=IDLE, counters=0.
- rb_n goes through a 2-flop synchroniser per bit. busy and eligibility use the synchronised value, so each has 2 cycles of latency from the pin.
- Eligibility: elig[i] = req[i] & rb_sync[i].
- Pick: the first eligible way searching ptr, ptr+1, ... modulo NUM_WAYS. This is combinational.
- All outputs are registered.
- States:
  - IDLE:
    - If any elig, register the pick: gnt[w]=1, cen[w]=0, gnt_id=w, ptr<=w+1 (wraps to 0), hold_cnt<=0, and go to GRANT.
    - Latency: gnt rises the cycle after elig is seen.
    - Otherwise stay in IDLE.
  - GRANT:
    - hold_cnt increments every cycle.
    - If release[gnt_id]=1: go to TURN (or IDLE if TURN_CYC=0). gnt and cen deassert on the next edge.
    - Else if hold_cnt=MAX_HOLD-1: do the same and pulse timeout_err for one cycle, aligned with gnt dropping.
    - release and the timeout in the same cycle count as a normal release, with no error.
    - release bits of non-owners are ignored.
    - Owner dropping req or going busy (rb_n low) during GRANT has no effect; ownership ends only by release or timeout.
  - TURN:
    - gnt=0 and all cen high for exactly TURN_CYC cycles, counted by turn_cnt, then IDLE.
    - Requests arriving during TURN wait.
- A way may be re-granted after TURN only if no other way is eligible, since ptr has already moved past it.
- At most one gnt bit is ever set. cen equals ~gnt at all times.
- Widths:
  - hold_cnt is clog2(MAX_HOLD) bits and never wraps, because it ends at MAX_HOLD-1.
  - ptr is clog2(NUM_WAYS) bits and wraps naturally.

Decomposition:
- Package nand_sched_pkg holds:
  - state enum {IDLE, GRANT, TURN}
  - default NUM_WAYS, TURN_CYC and MAX_HOLD constants
  - the WAY_W = clog2(NUM_WAYS) helper
- Sub-module nand_rr_pick: combinational rotate-priority-rotate-back picker, taking elig and ptr and returning a valid flag and an index. It is reused by a later per-bus DMA arbiter.
- The synchroniser stays inline in nand_bus_scheduler.

Test Plan:
- Reset while way 3 is granted (RST_N low mid-GRANT) -> cen=8'hFF and gnt=0 in the same time step; after deassertion, the first grant searches from way 0.
- req=8'b0000_0101, all ready -> way 0 granted 1 cycle later with cen=8'hFE; release[0] pulse -> 2 TURN cycles with cen=8'hFF -> way 2 granted with cen=8'hFB.
- All 8 requesting and ready, each owner releasing after 3 cycles -> grant order 0,1,...,7,0. Per owner: 1 grant cycle + 3 held cycles + 2 turn cycles, with no overlap of cen lows.
- req[4]=1 with rb_n[4]=0 -> never granted and busy[4]=1; rb_n[4] rises -> busy[4] clears after 2 cycles and gnt[4] rises 1 cycle later.
- MAX_HOLD=16, way 1 never releases -> gnt[1] held for exactly 16 cycles, then timeout_err=1 for 1 cycle; a release[5] pulse during the grant is ignored.
- TURN_CYC=0, ways 6 and 7 requesting -> after release[6], gnt switches straight to way 7 after a single IDLE cycle with cen=8'hFF.
